// File: rtl/issue_scheduler_if.sv
// Decode, scoreboard and dispatch signals of the single-entry issue scheduler.
// The scheduler takes the slave modport; its environment takes the master modport.
interface issue_scheduler_if;
  logic       id_valid;
  logic       id_ready;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_writes;
  logic [1:0] id_unit;
  logic       flush;
  logic [4:0] sb_addr_a;
  logic [4:0] sb_addr_b;
  logic [4:0] sb_waw_addr;
  logic       sb_pending_a;
  logic       sb_pending_b;
  logic       sb_waw_pending;
  logic [4:0] sb_writeaddr;
  logic [1:0] sb_registerunit;
  logic       sb_enablewrite;
  logic [2:0] iss_valid;
  logic [4:0] iss_rd;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_writes, id_unit, flush,
    output sb_pending_a, sb_pending_b, sb_waw_pending,
    input  id_ready, sb_addr_a, sb_addr_b, sb_waw_addr,
    input  sb_writeaddr, sb_registerunit, sb_enablewrite, iss_valid, iss_rd
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_writes, id_unit, flush,
    input  sb_pending_a, sb_pending_b, sb_waw_pending,
    output id_ready, sb_addr_a, sb_addr_b, sb_waw_addr,
    output sb_writeaddr, sb_registerunit, sb_enablewrite, iss_valid, iss_rd
  );
endinterface

// File: rtl/issue_scheduler.sv
// Single-entry in-order issue scheduler with RAW/WAW/writeback-port hazard checks.
// Define ISSUE_SCHED_STATS_EN to add the saturating stall_cycles counter output.
module issue_scheduler (
  input  logic               clock,
  input  logic               reset,
  issue_scheduler_if.slave   bus
`ifdef ISSUE_SCHED_STATS_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  typedef enum logic [0:0] {StEmpty, StHeld} state_e;

  state_e     state_q, state_d;
  logic [4:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic       uses_rs_q, uses_rs_d, uses_rt_q, uses_rt_d, writes_q, writes_d;
  logic [1:0] unit_q, unit_d;
  logic [4:0] wb_res_q, wb_res_d;
  logic [2:0] iss_valid_q, iss_valid_d;
  logic [4:0] iss_rd_q, iss_rd_d;

  logic       held, eff_write, raw_haz, waw_haz, struct_haz, illegal, issue, ready, accept;
  logic [2:0] slot;
  logic [2:0] unit_onehot;

  // Unit decode: writeback latency slot and dispatch lane.
  always_comb begin
    slot        = 3'd0;
    unit_onehot = 3'b000;
    illegal     = 1'b0;
    case (unit_q)
      2'b00:   begin slot = 3'd1; unit_onehot = 3'b001; end
      2'b01:   begin slot = 3'd2; unit_onehot = 3'b010; end
      2'b10:   begin slot = 3'd4; unit_onehot = 3'b100; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    held       = (state_q == StHeld);
    eff_write  = writes_q && (rd_q != 5'd0);
    raw_haz    = (uses_rs_q && (rs_q != 5'd0) && bus.sb_pending_a) ||
                 (uses_rt_q && (rt_q != 5'd0) && bus.sb_pending_b);
    waw_haz    = eff_write && bus.sb_waw_pending;
    struct_haz = eff_write && wb_res_q[slot];
    issue      = held && !bus.flush && !raw_haz && !waw_haz && !struct_haz && !illegal;
    // Gated by reset so every output reads 0 while reset is held low.
    ready      = reset && !bus.flush && (!held || issue);
    accept     = bus.id_valid && ready;
  end

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    uses_rs_d = uses_rs_q;
    uses_rt_d = uses_rt_q;
    writes_d  = writes_q;
    unit_d    = unit_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d   = StHeld;
      rs_d      = bus.id_rs;
      rt_d      = bus.id_rt;
      rd_d      = bus.id_rd;
      uses_rs_d = bus.id_uses_rs;
      uses_rt_d = bus.id_uses_rt;
      writes_d  = bus.id_writes;
      unit_d    = bus.id_unit;
    end else if (issue) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    wb_res_d    = wb_res_q >> 1;
    iss_valid_d = 3'b000;
    iss_rd_d    = iss_rd_q;
    if (issue) begin
      iss_valid_d = unit_onehot;
      iss_rd_d    = rd_q;
      if (eff_write) begin
        wb_res_d = wb_res_d | (5'd1 << slot);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rd_q        <= 5'd0;
      uses_rs_q   <= 1'b0;
      uses_rt_q   <= 1'b0;
      writes_q    <= 1'b0;
      unit_q      <= 2'b00;
      wb_res_q    <= 5'd0;
      iss_valid_q <= 3'b000;
      iss_rd_q    <= 5'd0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      uses_rs_q   <= uses_rs_d;
      uses_rt_q   <= uses_rt_d;
      writes_q    <= writes_d;
      unit_q      <= unit_d;
      wb_res_q    <= wb_res_d;
      iss_valid_q <= iss_valid_d;
      iss_rd_q    <= iss_rd_d;
    end
  end

  assign bus.id_ready        = ready;
  assign bus.sb_addr_a       = rs_q;
  assign bus.sb_addr_b       = rt_q;
  assign bus.sb_waw_addr     = rd_q;
  assign bus.sb_writeaddr    = rd_q;
  assign bus.sb_registerunit = unit_q;
  assign bus.sb_enablewrite  = issue && eff_write;
  assign bus.iss_valid       = iss_valid_q;
  assign bus.iss_rd          = iss_rd_q;

`ifdef ISSUE_SCHED_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (held && !issue && !bus.flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: back-to-back issue, RAW/WAW/structural stalls,
// flush, illegal unit and reset during a stall.
module tb_issue_scheduler;
  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  issue_scheduler_if bus ();

`ifdef ISSUE_SCHED_STATS_EN
  logic [15:0] stall_cycles;
  issue_scheduler dut (.clock(clock), .reset(reset), .bus(bus), .stall_cycles(stall_cycles));
`else
  issue_scheduler dut (.clock(clock), .reset(reset), .bus(bus));
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic present(input logic [1:0] unit, input logic [4:0] rd, input logic wr,
                         input logic [4:0] rs, input logic urs);
    bus.id_valid   = 1'b1;
    bus.id_unit    = unit;
    bus.id_rd      = rd;
    bus.id_writes  = wr;
    bus.id_rs      = rs;
    bus.id_uses_rs = urs;
    bus.id_rt      = 5'd0;
    bus.id_uses_rt = 1'b0;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;
  endtask

  initial begin
    reset              = 1'b0;
    bus.id_valid       = 1'b0;
    bus.id_rs          = 5'd0;
    bus.id_rt          = 5'd0;
    bus.id_uses_rs     = 1'b0;
    bus.id_uses_rt     = 1'b0;
    bus.id_rd          = 5'd0;
    bus.id_writes      = 1'b0;
    bus.id_unit        = 2'b00;
    bus.flush          = 1'b0;
    bus.sb_pending_a   = 1'b0;
    bus.sb_pending_b   = 1'b0;
    bus.sb_waw_pending = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", bus.id_ready, 0);
    chk("rst_iss_valid", bus.iss_valid, 0);
    chk("rst_iss_rd", bus.iss_rd, 0);
    chk("rst_claim", bus.sb_enablewrite, 0);
    tick();
    tick();
    reset = 1'b1;
    settle();
    chk("idle_ready", bus.id_ready, 1);

    // Back-to-back AluMisc rd=5 then Mem rd=6
    present(2'b00, 5'd5, 1'b1, 5'd0, 1'b0);
    settle();
    chk("b2b_ready0", bus.id_ready, 1);
    chk("b2b_noclaim0", bus.sb_enablewrite, 0);
    tick();
    present(2'b01, 5'd6, 1'b1, 5'd0, 1'b0);
    settle();
    chk("b2b_claim1", bus.sb_enablewrite, 1);
    chk("b2b_addr1", bus.sb_writeaddr, 5);
    chk("b2b_unit1", bus.sb_registerunit, 0);
    chk("b2b_ready1", bus.id_ready, 1);
    chk("b2b_nodisp1", bus.iss_valid, 0);
    tick();
    idle();
    settle();
    chk("b2b_claim2", bus.sb_enablewrite, 1);
    chk("b2b_addr2", bus.sb_writeaddr, 6);
    chk("b2b_unit2", bus.sb_registerunit, 1);
    chk("b2b_disp_alu", bus.iss_valid, 3'b001);
    chk("b2b_rd_alu", bus.iss_rd, 5);
    tick();
    settle();
    chk("b2b_disp_mem", bus.iss_valid, 3'b010);
    chk("b2b_rd_mem", bus.iss_rd, 6);
    chk("b2b_claim3", bus.sb_enablewrite, 0);
    repeat (5) tick();

    // RAW stall on rs=3 for three cycles
    present(2'b00, 5'd7, 1'b1, 5'd3, 1'b1);
    tick();
    idle();
    bus.sb_pending_a = 1'b1;
    settle();
    chk("raw_addr_a", bus.sb_addr_a, 3);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("raw_ready", bus.id_ready, 0);
      chk("raw_noclaim", bus.sb_enablewrite, 0);
      chk("raw_nodisp", bus.iss_valid, 0);
      tick();
    end
    bus.sb_pending_a = 1'b0;
    settle();
    chk("raw_claim", bus.sb_enablewrite, 1);
    chk("raw_ready_issue", bus.id_ready, 1);
    tick();
    settle();
    chk("raw_disp", bus.iss_valid, 3'b001);
    chk("raw_rd", bus.iss_rd, 7);
`ifdef ISSUE_SCHED_STATS_EN
    chk("raw_stall_cnt", stall_cycles, 3);
`endif
    repeat (5) tick();

    // Structural: Mult issue at T, AluMisc held at T+4 collides on the writeback port
    present(2'b10, 5'd9, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    settle();
    chk("str_mult_claim", bus.sb_enablewrite, 1);
    chk("str_mult_unit", bus.sb_registerunit, 2);
    tick();
    settle();
    chk("str_mult_disp", bus.iss_valid, 3'b100);
    tick();
    tick();
    present(2'b00, 5'd10, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    settle();
    chk("str_stall", bus.sb_enablewrite, 0);
    chk("str_ready", bus.id_ready, 0);
    tick();
    settle();
    chk("str_claim", bus.sb_enablewrite, 1);
    chk("str_addr", bus.sb_writeaddr, 10);
    tick();
    settle();
    chk("str_disp", bus.iss_valid, 3'b001);
    chk("str_rd", bus.iss_rd, 10);
    repeat (3) tick();

    // WAW stall on a real destination
    present(2'b00, 5'd12, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    bus.sb_waw_pending = 1'b1;
    settle();
    chk("waw_stall", bus.sb_enablewrite, 0);
    chk("waw_addr", bus.sb_waw_addr, 12);
    tick();
    bus.sb_waw_pending = 1'b0;
    settle();
    chk("waw_claim", bus.sb_enablewrite, 1);
    tick();

    // rd=0 write ignores WAW and reserves nothing; the next AluMisc write follows at once
    present(2'b00, 5'd0, 1'b1, 5'd0, 1'b0);
    tick();
    bus.sb_waw_pending = 1'b1;
    present(2'b00, 5'd11, 1'b1, 5'd0, 1'b0);
    settle();
    chk("rd0_noclaim", bus.sb_enablewrite, 0);
    chk("rd0_ready", bus.id_ready, 1);
    tick();
    bus.sb_waw_pending = 1'b0;
    idle();
    settle();
    chk("rd0_next_claim", bus.sb_enablewrite, 1);
    chk("rd0_disp", bus.iss_valid, 3'b001);
    chk("rd0_iss_rd", bus.iss_rd, 0);
    tick();
    settle();
    chk("rd0_next_rd", bus.iss_rd, 11);
    repeat (3) tick();

    // Flush while HELD; Mult reservation survives the flush
    present(2'b10, 5'd13, 1'b1, 5'd0, 1'b0);
    tick();
    present(2'b00, 5'd14, 1'b1, 5'd0, 1'b0);
    settle();
    chk("fl_mult_claim", bus.sb_enablewrite, 1);
    tick();
    bus.flush = 1'b1;
    present(2'b00, 5'd15, 1'b1, 5'd0, 1'b0);
    settle();
    chk("fl_ready", bus.id_ready, 0);
    chk("fl_noclaim", bus.sb_enablewrite, 0);
    chk("fl_mult_disp", bus.iss_valid, 3'b100);
    tick();
    bus.flush = 1'b0;
    idle();
    settle();
    chk("fl_nodisp", bus.iss_valid, 0);
    chk("fl_iss_rd", bus.iss_rd, 13);
    chk("fl_empty", bus.id_ready, 1);
    tick();
    present(2'b00, 5'd16, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    settle();
    chk("fl_persist", bus.sb_enablewrite, 0);
    tick();
    settle();
    chk("fl_late_claim", bus.sb_enablewrite, 1);
    chk("fl_late_addr", bus.sb_writeaddr, 16);
    repeat (3) tick();

    // Illegal unit never issues
    present(2'b11, 5'd20, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    settle();
    chk("ill_noclaim", bus.sb_enablewrite, 0);
    chk("ill_ready", bus.id_ready, 0);
    tick();
    settle();
    chk("ill_nodisp", bus.iss_valid, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();

    // Reset during a RAW stall
    present(2'b00, 5'd17, 1'b1, 5'd4, 1'b1);
    tick();
    idle();
    bus.sb_pending_a = 1'b1;
    settle();
    chk("rs_stall", bus.sb_enablewrite, 0);
    reset = 1'b0;
    #1;
    chk("rs_ready", bus.id_ready, 0);
    chk("rs_addr_a", bus.sb_addr_a, 0);
    chk("rs_iss_rd", bus.iss_rd, 0);
    chk("rs_iss_valid", bus.iss_valid, 0);
    chk("rs_claim", bus.sb_enablewrite, 0);
    tick();
    reset = 1'b1;
    bus.sb_pending_a = 1'b0;
    settle();
    chk("rs_post_nodisp", bus.iss_valid, 0);
    chk("rs_post_ready", bus.id_ready, 1);
    chk("rs_post_noclaim", bus.sb_enablewrite, 0);
`ifdef ISSUE_SCHED_STATS_EN
    chk("rs_stall_cnt", stall_cycles, 0);
`endif
    present(2'b00, 5'd18, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    settle();
    chk("rs_new_claim", bus.sb_enablewrite, 1);
    chk("rs_new_addr", bus.sb_writeaddr, 18);
    tick();
    settle();
    chk("rs_new_disp", bus.iss_valid, 3'b001);
    chk("rs_new_rd", bus.iss_rd, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
